// File: rtl/decode_if.sv
// Fetch/execute-facing signal bundle of the RV32I decode stage.
// The slave modport is the decode stage; the master modport is its surrounding pipeline.
interface decode_if;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_ce;
    logic        i_stall;
    logic        i_flush;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [4:0]  o_rs1_addr_q;
    logic [4:0]  o_rs2_addr_q;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_imm;
    logic [2:0]  o_funct3;
    logic [13:0] o_alu_op;
    logic [10:0] o_opcode;
    logic [3:0]  o_exception;
    logic [31:0] o_pc;
    logic        o_ce;
    logic        o_stall;
    logic        o_flush;

    modport master (
        output i_pc, i_instr, i_ce, i_stall, i_flush,
        input  o_rs1_addr, o_rs2_addr, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr, o_imm,
               o_funct3, o_alu_op, o_opcode, o_exception, o_pc, o_ce, o_stall, o_flush
    );

    modport slave (
        input  i_pc, i_instr, i_ce, i_stall, i_flush,
        output o_rs1_addr, o_rs2_addr, o_rs1_addr_q, o_rs2_addr_q, o_rd_addr, o_imm,
               o_funct3, o_alu_op, o_opcode, o_exception, o_pc, o_ce, o_stall, o_flush
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: registers fetched pc/instruction as decoded fields (one-hot ALU op and
// opcode class, sign-extended immediate, exception flags) and relays the ce/stall/flush chain.
module decode_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rstn,
    decode_if.slave  bus
);
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [10:0] CLS_RTYPE  = 11'h001;
    localparam logic [10:0] CLS_ITYPE  = 11'h002;
    localparam logic [10:0] CLS_LOAD   = 11'h004;
    localparam logic [10:0] CLS_STORE  = 11'h008;
    localparam logic [10:0] CLS_BRANCH = 11'h010;
    localparam logic [10:0] CLS_JAL    = 11'h020;
    localparam logic [10:0] CLS_JALR   = 11'h040;
    localparam logic [10:0] CLS_LUI    = 11'h080;
    localparam logic [10:0] CLS_AUIPC  = 11'h100;
    localparam logic [10:0] CLS_SYSTEM = 11'h200;
    localparam logic [10:0] CLS_FENCE  = 11'h400;

    localparam logic [13:0] ALU_ADD  = 14'h0001;
    localparam logic [13:0] ALU_SUB  = 14'h0002;
    localparam logic [13:0] ALU_SLT  = 14'h0004;
    localparam logic [13:0] ALU_SLTU = 14'h0008;
    localparam logic [13:0] ALU_XOR  = 14'h0010;
    localparam logic [13:0] ALU_OR   = 14'h0020;
    localparam logic [13:0] ALU_AND  = 14'h0040;
    localparam logic [13:0] ALU_SLL  = 14'h0080;
    localparam logic [13:0] ALU_SRL  = 14'h0100;
    localparam logic [13:0] ALU_SRA  = 14'h0200;
    localparam logic [13:0] ALU_EQ   = 14'h0400;
    localparam logic [13:0] ALU_NEQ  = 14'h0800;
    localparam logic [13:0] ALU_GE   = 14'h1000;
    localparam logic [13:0] ALU_GEU  = 14'h2000;

    // Decode never stalls on its own; kept as a named term so the stall chain reads clearly.
    localparam logic STALL_DECODE = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [13:0] alu;
        logic [10:0] opc;
        logic [3:0]  exc;
    } dec_t;

    function automatic logic [13:0] arith_op(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'b000:  arith_op = (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    endfunction

    function automatic logic [13:0] branch_op(input logic [2:0] f3);
        case (f3)
            3'b000:  branch_op = ALU_EQ;
            3'b001:  branch_op = ALU_NEQ;
            3'b100:  branch_op = ALU_SLT;
            3'b101:  branch_op = ALU_GE;
            3'b110:  branch_op = ALU_SLTU;
            3'b111:  branch_op = ALU_GEU;
            default: branch_op = ALU_ADD;
        endcase
    endfunction

    logic [1:0]  rst_sync_d, rst_sync_q;
    logic        rst_int_n;
    logic [31:0] instr_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s;
    logic [10:0] cls_s;
    logic [13:0] alu_s;
    logic [31:0] imm_s;
    logic        bad_s, illegal_s, ecall_s, ebreak_s, mret_s;
    logic        stall_bit_s, load_s;
    dec_t        dec_s, dec_d, dec_q;
    logic        ce_d, ce_q;

    assign instr_s  = bus.i_instr;
    assign f3_s     = instr_s[14:12];
    assign f7_s     = instr_s[31:25];
    assign imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_st_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    assign imm_u_s  = {instr_s[31:12], 12'h000};
    assign imm_j_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

    // Release edge of rstn is retimed to clk; assertion still clears everything at once.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_q <= 2'b00;
        else       rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    // Opcode-class decode with the per-class legality rules.
    always_comb begin
        cls_s    = 11'h000;
        alu_s    = ALU_ADD;
        imm_s    = 32'h0000_0000;
        bad_s    = 1'b0;
        ecall_s  = 1'b0;
        ebreak_s = 1'b0;
        mret_s   = 1'b0;
        case (instr_s[6:0])
            OPC_RTYPE: begin
                cls_s = CLS_RTYPE;
                alu_s = arith_op(f3_s, instr_s[30], 1'b1);
                bad_s = !((f7_s == 7'h00) ||
                          ((f7_s == 7'h20) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
            end
            OPC_ITYPE:  begin cls_s = CLS_ITYPE; alu_s = arith_op(f3_s, instr_s[30], 1'b0); imm_s = imm_i_s; end
            OPC_LOAD:   begin cls_s = CLS_LOAD;  imm_s = imm_i_s;  end
            OPC_STORE:  begin cls_s = CLS_STORE; imm_s = imm_st_s; end
            OPC_BRANCH: begin
                cls_s = CLS_BRANCH;
                alu_s = branch_op(f3_s);
                imm_s = imm_b_s;
                bad_s = (f3_s == 3'b010) || (f3_s == 3'b011);
            end
            OPC_JAL:    begin cls_s = CLS_JAL;   imm_s = imm_j_s; end
            OPC_JALR:   begin cls_s = CLS_JALR;  imm_s = imm_i_s; end
            OPC_LUI:    begin cls_s = CLS_LUI;   imm_s = imm_u_s; end
            OPC_AUIPC:  begin cls_s = CLS_AUIPC; imm_s = imm_u_s; end
            OPC_SYSTEM: begin
                // funct3=000 admits only the three privileged words; CSR ops carry an I-immediate.
                cls_s    = CLS_SYSTEM;
                ecall_s  = (instr_s == 32'h0000_0073);
                ebreak_s = (instr_s == 32'h0010_0073);
                mret_s   = (instr_s == 32'h3020_0073);
                imm_s    = (f3_s == 3'b000) ? 32'h0000_0000 : imm_i_s;
                bad_s    = (f3_s == 3'b000) && !(ecall_s || ebreak_s || mret_s);
            end
            OPC_FENCE:  begin cls_s = CLS_FENCE; end
            default:    begin bad_s = 1'b1; end
        endcase
    end

    assign illegal_s = bad_s || (instr_s[1:0] != 2'b11);

    // Assemble the decoded record; an illegal word carries no class, ADD and a zero immediate.
    always_comb begin
        dec_s.pc     = bus.i_pc;
        dec_s.rd     = instr_s[11:7];
        dec_s.rs1    = instr_s[19:15];
        dec_s.rs2    = instr_s[24:20];
        dec_s.funct3 = f3_s;
        dec_s.imm    = illegal_s ? 32'h0000_0000 : imm_s;
        dec_s.alu    = illegal_s ? ALU_ADD : alu_s;
        dec_s.opc    = illegal_s ? 11'h000 : cls_s;
        dec_s.exc    = illegal_s ? 4'b0001 : {mret_s, ebreak_s, ecall_s, 1'b0};
    end

    assign stall_bit_s = bus.i_stall | STALL_DECODE;
    assign load_s      = bus.i_ce & ~stall_bit_s;

    // Next state: data loads on accepted fetch; ce follows flush > fetch ce > bubble > hold.
    always_comb begin
        dec_d = load_s ? dec_s : dec_q;
        if (!stall_bit_s && bus.i_flush) begin
            ce_d = 1'b0;
        end else if (!stall_bit_s) begin
            ce_d = bus.i_ce;
        end else if (!bus.i_stall) begin
            ce_d = 1'b0;
        end else begin
            ce_d = ce_q;
        end
    end

    // Pipeline register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            dec_q <= '{pc: PC_RESET, default: '0};
            ce_q  <= 1'b0;
        end else begin
            dec_q <= dec_d;
            ce_q  <= ce_d;
        end
    end

    assign bus.o_rs1_addr   = instr_s[19:15];
    assign bus.o_rs2_addr   = instr_s[24:20];
    assign bus.o_rs1_addr_q = dec_q.rs1;
    assign bus.o_rs2_addr_q = dec_q.rs2;
    assign bus.o_rd_addr    = dec_q.rd;
    assign bus.o_imm        = dec_q.imm;
    assign bus.o_funct3     = dec_q.funct3;
    assign bus.o_alu_op     = dec_q.alu;
    assign bus.o_opcode     = dec_q.opc;
    assign bus.o_exception  = dec_q.exc;
    assign bus.o_pc         = dec_q.pc;
    assign bus.o_ce         = ce_q;
    assign bus.o_stall      = stall_bit_s;
    assign bus.o_flush      = bus.i_flush;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage against a field-level RV32I reference model.
module tb_decode_stage;
    localparam logic [31:0] PC_RST = 32'h0000_0080;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [13:0] alu;
        logic [10:0] opc;
        logic [3:0]  exc;
    } exp_t;

    // Bit positions: alu {GEU13,GE12,NEQ11,EQ10,SRA9,SRL8,SLL7,AND6,OR5,XOR4,SLTU3,SLT2,SUB1,ADD0}
    localparam int F3_BIT [8] = '{0, 7, 2, 3, 4, 8, 5, 6};
    localparam int BR_BIT [8] = '{10, 11, 0, 0, 2, 12, 3, 13};
    localparam logic [6:0] OPCS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                         7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    localparam logic [31:0] SYS_WORDS [5] = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073,
                                              32'h1050_0073, 32'h0000_1073};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    decode_if bus();
    decode_stage #(.PC_RESET(PC_RST)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: classify by opcode index, apply legality rules, build fields arithmetically.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w);
        exp_t e;
        int cls = -1;
        int ab = 0;
        int v = 0;
        bit bad, ec, eb, mr;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        for (int k = 0; k < 11; k++) if (w[6:0] == OPCS[k]) cls = k;
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
        ec = (w == SYS_WORDS[0]); eb = (w == SYS_WORDS[1]); mr = (w == SYS_WORDS[2]);
        bad = (cls < 0) || (w[1:0] != 2'b11);
        if (cls == 4 && (f3 == 3'd2 || f3 == 3'd3)) bad = 1'b1;
        if (cls == 0 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
        if (cls == 9 && f3 == 3'd0 && !(ec || eb || mr)) bad = 1'b1;
        case (cls)
            1, 2, 6: v = $signed(w[31:20]);
            3:       v = $signed({w[31:25], w[11:7]});
            4:       v = $signed({w[31], w[7], w[30:25], w[11:8]}) * 2;
            5:       v = $signed({w[31], w[19:12], w[20], w[30:21]}) * 2;
            7, 8:    v = int'(w & 32'hFFFF_F000);
            9:       v = (f3 != 3'd0) ? $signed(w[31:20]) : 0;
            default: v = 0;
        endcase
        if (cls == 0 || cls == 1) begin
            ab = F3_BIT[f3];
            if (cls == 0 && f3 == 3'd0 && w[30]) ab = 1;
            if (f3 == 3'd5 && w[30]) ab = 9;
        end
        if (cls == 4) ab = BR_BIT[f3];
        if (bad) begin
            e.opc = 11'h000; e.alu = 14'h0001; e.imm = 32'h0; e.exc = 4'b0001;
        end else begin
            e.opc = 11'h001 << cls; e.alu = 14'h0001 << ab; e.imm = v; e.exc = {mr, eb, ec, 1'b0};
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 19);
        if (k < 11) w[6:0] = OPCS[k];
        else if (k == 13) w = SYS_WORDS[$urandom_range(0, 4)];
        else if (k < 17 && k > 13) begin
            w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (k >= 17) begin
            w[6:0] = 7'h13; w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001;
        end
        return w;
    endfunction

    function automatic exp_t snap();
        exp_t c;
        c.pc = bus.o_pc; c.rd = bus.o_rd_addr; c.rs1 = bus.o_rs1_addr_q; c.rs2 = bus.o_rs2_addr_q;
        c.imm = bus.o_imm; c.f3 = bus.o_funct3; c.alu = bus.o_alu_op; c.opc = bus.o_opcode;
        c.exc = bus.o_exception;
        return c;
    endfunction

    task automatic cmp_all(input string p, input exp_t a, input exp_t e);
        chk({p, "_pc"}, a.pc, e.pc);       chk({p, "_rd"}, 32'(a.rd), 32'(e.rd));
        chk({p, "_rs1q"}, 32'(a.rs1), 32'(e.rs1)); chk({p, "_rs2q"}, 32'(a.rs2), 32'(e.rs2));
        chk({p, "_imm"}, a.imm, e.imm);    chk({p, "_funct3"}, 32'(a.f3), 32'(e.f3));
        chk({p, "_alu"}, 32'(a.alu), 32'(e.alu)); chk({p, "_opcode"}, 32'(a.opc), 32'(e.opc));
        chk({p, "_exc"}, 32'(a.exc), 32'(e.exc));
    endtask

    task automatic chk_reset();
        exp_t r;
        r = '0; r.pc = PC_RST;
        cmp_all("reset", snap(), r);
        chk("reset_ce", 32'(bus.o_ce), 32'h0);
    endtask

    // Monitor: samples inputs at the edge, checks outputs 1 ns later.
    initial begin
        exp_t prev = '0;
        logic prev_ce = 1'b0;
        forever begin
            logic s_stall, s_ce, s_flush, s_en;
            exp_t cur, e;
            @(posedge clk);
            s_stall = bus.i_stall; s_ce = bus.i_ce; s_flush = bus.i_flush; s_en = mon_en && rstn;
            #1;
            cur = snap();
            if (s_en && rstn) begin
                chk("o_stall", 32'(bus.o_stall), 32'(s_stall));
                chk("o_flush", 32'(bus.o_flush), 32'(s_flush));
                chk("o_rs1_addr", 32'(bus.o_rs1_addr), 32'(bus.i_instr[19:15]));
                chk("o_rs2_addr", 32'(bus.o_rs2_addr), 32'(bus.i_instr[24:20]));
                if (!s_stall) begin
                    chk("o_ce", 32'(bus.o_ce), 32'(s_ce && !s_flush));
                    if (bus.o_ce) begin
                        if (q.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
                        else begin
                            e = q.pop_front();
                            cmp_all("dec", cur, e);
                        end
                    end
                end else begin
                    chk("stall_ce_hold", 32'(bus.o_ce), 32'(prev_ce));
                    cmp_all("stall_hold", cur, prev);
                end
            end
            prev = cur;
            prev_ce = bus.o_ce;
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] w, input logic ce,
                         input logic stall, input logic flush);
        @(posedge clk);
        #2;
        bus.i_pc = pc; bus.i_instr = w; bus.i_ce = ce; bus.i_stall = stall; bus.i_flush = flush;
        if (ce && !stall && !flush) q.push_back(model(pc, w));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            drive($urandom & 32'hFFFF_FFFC, rand_instr(), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
    endtask

    task automatic reset_now();
        mon_en = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset();
        bus.i_ce = 1'b0; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        mon_en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_pc = 32'h0; bus.i_instr = 32'h0; bus.i_ce = 1'b0; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
        #12;
        reset_now();
        drive(32'h100, 32'h0051_0093, 1'b1, 1'b0, 1'b0);
        drive(32'h104, 32'h4020_81B3, 1'b1, 1'b0, 1'b0);
        drive(32'h108, 32'hFE00_0EE3, 1'b1, 1'b0, 1'b0);
        drive(32'h10C, 32'h0000_0073, 1'b1, 1'b0, 1'b0);
        drive(32'h110, 32'h3020_0073, 1'b1, 1'b0, 1'b0);
        drive(32'h114, 32'h0000_4501, 1'b1, 1'b0, 1'b0);
        drive(32'h118, 32'h0010_0073, 1'b1, 1'b0, 1'b0);
        drive(32'h11C, 32'h3000_2573, 1'b1, 1'b0, 1'b0);
        drive(32'h120, 32'h4050_D093, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(32'h124, 32'h0020_8233, 1'b1, 1'b1, 1'b0);
        drive(32'h124, 32'h0020_8233, 1'b1, 1'b0, 1'b0);
        drive(32'h128, 32'h0000_0013, 1'b1, 1'b0, 1'b1);
        drive(32'h12C, 32'h0041_A023, 1'b1, 1'b0, 1'b0);
        drive(32'h130, 32'h0000_006F, 1'b1, 1'b1, 1'b1);
        drive(32'h130, 32'h0000_006F, 1'b1, 1'b0, 1'b1);
        drive(32'h134, 32'hABCD_E537, 1'b1, 1'b0, 1'b0);
        random_run(300);
        reset_now();
        random_run(150);
        idle(3);
        #2;
        chk("sb_drained", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
